apb_cmd_master: RTL and testbench
=================================

// Module: apb_cmd_master
// PURPOSE
//  APB3 initiator: turns a valid/ready command stream (e.g. from a DMA or
//  debug engine) into single APB transfers toward peripheral slaves such as
//  the timer blocks. Sits between the command source and the APB slave
//  decode. One outstanding transfer. The response is returned on a
//  valid/ready channel.
// PARAMETERS
//  ADDR_W       32   width of cmd_addr/paddr
//  TIMEOUT_CYC  256  ACCESS-phase cycles before abort (APB_MST_TIMEOUT_EN only)
// PORTS
//  pclk         in   1       clock, single clock domain
//  preset       in   1       asynchronous reset, active-high
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       command accepted when valid&ready
//  cmd_addr     in   ADDR_W  target address
//  cmd_write    in   1       1=write, 0=read
//  cmd_wdata    in   32      write data
//  cmd_prot     in   3       protection attributes, passed to pprot
//  rsp_valid    out  1       response present
//  rsp_ready    in   1       response consumed when valid&ready
//  rsp_rdata    out  32      read data (0 for writes and aborted reads)
//  rsp_err      out  1       pslverr sampled, or timeout
//  rsp_timeout  out  1       transfer aborted by timeout
//  psel         out  1       APB select
//  penable      out  1       APB enable
//  paddr        out  ADDR_W  APB address
//  pwrite       out  1       APB direction
//  pwdata       out  32      APB write data
//  pprot        out  3       APB protection
//  prdata       in   32      APB read data
//  pready       in   1       APB ready
//  pslverr      in   1       APB slave error
// BEHAVIOUR
//  - All outputs registered. Reset value of every output is 0, except
//    cmd_ready, which is 1. The FSM resets to IDLE.
//  - FSM states: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//  - IDLE: cmd_ready=1. On cmd_valid, latch addr/write/wdata/prot onto
//    paddr/pwrite/pwdata/pprot, go to SETUP, and drop cmd_ready.
//  - SETUP: psel=1, penable=0, for exactly one cycle, then go to ACCESS.
//  - ACCESS: psel=1, penable=1. Hold until pready=1.
//    On pready: sample prdata (reads only) and pslverr into rsp_*.
//    Drop psel/penable and go to RESP.
//  - RESP: rsp_valid=1, stable until rsp_ready. On rsp_ready, clear
//    rsp_valid, set cmd_ready=1, and go to IDLE.
//  - Latency: command accepted at cycle N -> psel at N+1 -> penable at N+2
//    -> rsp_valid at N+3 when pready=1 at N+2. Each pready wait cycle adds 1.
//  - Back-to-back: the next command can only be accepted in the cycle
//    after the response handshake. Minimum 4 cycles per transfer.
//  - paddr/pwrite/pwdata/pprot hold their last values outside transfers.
//    They are stable through SETUP and ACCESS.
//  - pslverr is honoured only in the pready cycle; ignored otherwise.
//    pready is ignored outside ACCESS.
//  - Writes: rsp_rdata=0.
//  - preset asserted mid-transfer: psel/penable drop immediately, the FSM
//    returns to IDLE, and any pending response is lost.
// CONFIGURATION
//  APB_MST_TIMEOUT_EN defined:
//    - A counter clears on entry to ACCESS and counts each cycle without
//      pready.
//    - When it reaches TIMEOUT_CYC-1 with pready still low: drop
//      psel/penable, set rsp_err=1, rsp_timeout=1, rsp_rdata=0, and go to
//      RESP.
//    - pready in that same cycle wins (normal completion).
//  APB_MST_TIMEOUT_EN undefined:
//    - No counter; ACCESS waits indefinitely.
//    - rsp_timeout is tied to 0.
// TESTING
//  1. Read, addr 0x40011004, slave returns pready=1 first ACCESS cycle,
//     prdata=0xA5A5_1234 -> psel N+1, penable N+2, rsp_valid N+3,
//     rsp_rdata=0xA5A51234, rsp_err=0.
//  2. Write 0xDEADBEEF to 0x40011000, pready low for 3 cycles ->
//     pwdata/paddr stable throughout; rsp_valid at N+6; rsp_rdata=0.
//  3. Read with pslverr=1 in the pready cycle -> rsp_err=1;
//     pslverr=1 in a non-pready cycle -> rsp_err=0.
//  4. rsp_ready held low for 5 cycles with cmd_valid high -> cmd_ready
//     stays 0, psel=0, response stable; accepted cycle after handshake.
//  5. preset pulsed during ACCESS -> psel=penable=rsp_valid=0,
//     cmd_ready=1 next edge; a following read completes normally.
//  6. (APB_MST_TIMEOUT_EN, TIMEOUT_CYC=8) pready never asserted ->
//     penable drops after 8 ACCESS cycles; rsp_err=1, rsp_timeout=1.

Source files
------------

// File: rtl/apb_cmd_master_if.sv
// apb_cmd_master_if
//   Bundles the command stream, the response stream and the APB3 bus of
//   apb_cmd_master into one interface.
//   Signals:
//     cmd_valid/cmd_ready/cmd_addr/cmd_write/cmd_wdata/cmd_prot  command in
//     rsp_valid/rsp_ready/rsp_rdata/rsp_err/rsp_timeout          response out
//     psel/penable/paddr/pwrite/pwdata/pprot                     APB request
//     prdata/pready/pslverr                                      APB completion
//   Modports:
//     master : the APB initiator (drives cmd_ready, rsp_*, APB request)
//     slave  : the environment around it (command source, response sink,
//              APB slave)
interface apb_cmd_master_if #(
   parameter int ADDR_W = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic              cmd_write;
   logic [31:0]       cmd_wdata;
   logic [2:0]        cmd_prot;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;
   logic              rsp_timeout;

   logic              psel;
   logic              penable;
   logic [ADDR_W-1:0] paddr;
   logic              pwrite;
   logic [31:0]       pwdata;
   logic [2:0]        pprot;
   logic [31:0]       prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_prot,
      input  rsp_ready,
      input  prdata, pready, pslverr,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      output psel, penable, paddr, pwrite, pwdata, pprot
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_prot,
      output rsp_ready,
      output prdata, pready, pslverr,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      input  psel, penable, paddr, pwrite, pwdata, pprot
   );
endinterface

// File: rtl/apb_cmd_master.sv
// apb_cmd_master
//   APB3 initiator. Converts a valid/ready command stream into single APB
//   transfers (one outstanding) and returns the result on a valid/ready
//   response channel. All outputs are registered.
//   Ports:
//     pclk    clock
//     preset  asynchronous reset, active-high
//     bus     apb_cmd_master_if.master (command, response and APB signals)
//   Parameters:
//     ADDR_W       address width of cmd_addr/paddr
//     TIMEOUT_CYC  ACCESS-phase cycles before abort
//   Build option:
//     APB_MST_TIMEOUT_EN  when defined, an ACCESS phase with no pready for
//                         TIMEOUT_CYC cycles is aborted and reported with
//                         rsp_err=1, rsp_timeout=1. When undefined ACCESS
//                         waits forever and rsp_timeout is tied to 0.
module apb_cmd_master #(
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 256
) (
   input logic              pclk,
   input logic              preset,
   apb_cmd_master_if.master bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   if (TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("apb_cmd_master: TIMEOUT_CYC must be at least 1");
   end

   state_t            state_q, state_d;

   logic              cmd_ready_q, cmd_ready_d;
   logic              psel_q,      psel_d;
   logic              penable_q,   penable_d;
   logic [ADDR_W-1:0] paddr_q,     paddr_d;
   logic              pwrite_q,    pwrite_d;
   logic [31:0]       pwdata_q,    pwdata_d;
   logic [2:0]        pprot_q,     pprot_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [31:0]       rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q,   rsp_err_d;

   // High in the ACCESS cycle that must be aborted (pready still low).
   logic              timeout_hit;

`ifdef APB_MST_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic              rsp_timeout_q, rsp_timeout_d;

   // A pready arriving in the final allowed cycle completes normally.
   assign timeout_hit = (state_q == ACCESS) && !bus.pready &&
                        (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   // State register
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.cmd_valid)                state_d = SETUP;
         SETUP:                                     state_d = ACCESS;
         ACCESS:  if (bus.pready || timeout_hit)    state_d = RESP;
         RESP:    if (bus.rsp_ready)                state_d = IDLE;
         default:                                   state_d = IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs
   always_comb begin
      cmd_ready_d = cmd_ready_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      pprot_d     = pprot_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
`ifdef APB_MST_TIMEOUT_EN
      tmo_cnt_d     = tmo_cnt_q;
      rsp_timeout_d = rsp_timeout_q;
`endif
      case (state_q)
         IDLE: begin
            // cmd_ready is high throughout IDLE, so cmd_valid alone is the
            // handshake.
            if (bus.cmd_valid) begin
               paddr_d     = bus.cmd_addr;
               pwrite_d    = bus.cmd_write;
               pwdata_d    = bus.cmd_wdata;
               pprot_d     = bus.cmd_prot;
               cmd_ready_d = 1'b0;
               psel_d      = 1'b1;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
`ifdef APB_MST_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
         end
         ACCESS: begin
            if (bus.pready) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = pwrite_q ? 32'h0 : bus.prdata;
               rsp_err_d   = bus.pslverr;
`ifdef APB_MST_TIMEOUT_EN
               rsp_timeout_d = 1'b0;
`endif
            end else if (timeout_hit) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = 32'h0;
               rsp_err_d   = 1'b1;
`ifdef APB_MST_TIMEOUT_EN
               rsp_timeout_d = 1'b1;
`endif
            end else begin
`ifdef APB_MST_TIMEOUT_EN
               tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
            end
         end
         default: begin
            cmd_ready_d = 1'b1;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   // Output registers
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         cmd_ready_q <= 1'b1;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         pprot_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         cmd_ready_q <= cmd_ready_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         pprot_q     <= pprot_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

`ifdef APB_MST_TIMEOUT_EN
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         tmo_cnt_q     <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         tmo_cnt_q     <= tmo_cnt_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign bus.rsp_timeout = rsp_timeout_q;
`else
   assign bus.rsp_timeout = 1'b0;
`endif

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.psel      = psel_q;
   assign bus.penable   = penable_q;
   assign bus.paddr     = paddr_q;
   assign bus.pwrite    = pwrite_q;
   assign bus.pwdata    = pwdata_q;
   assign bus.pprot     = pprot_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master
//   Self-checking bench for apb_cmd_master. A task-level APB slave and
//   response sink drive the DUT; expected responses and latencies come from
//   a transaction-level model. Compile with +define+APB_MST_TIMEOUT_EN to
//   also exercise the ACCESS timeout (TIMEOUT_CYC=8).
module tb_apb_cmd_master;

   localparam int ADDR_W = 32;
   localparam int TCYC   = 8;

   logic pclk = 1'b0;
   logic preset = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc <= cyc + 1;

   apb_cmd_master_if #(.ADDR_W(ADDR_W)) bus ();

   apb_cmd_master #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TCYC)) dut (
      .pclk   (pclk),
      .preset (preset),
      .bus    (bus)
   );

   typedef struct {
      int          lat;
      logic [31:0] rdata;
      logic        err;
      logic        tmo;
      int          acc_cycles;
   } exp_t;

   typedef struct {
      bit          done;
      int          acc_cyc;
      int          lat_psel;
      int          lat_pen;
      int          lat_rsp;
      int          acc_cycles;
      logic [31:0] rdata;
      logic        err;
      logic        tmo;
      bit          bus_ok;
      bit          hold_ok;
      bit          post_ok;
   } obs_t;

   // Transaction-level model: waits = ACCESS cycles with pready low before
   // the slave answers (-1 = never answers).
   function automatic exp_t model(bit wr, logic [31:0] rd, bit err_rdy, int waits);
      exp_t e;
`ifdef APB_MST_TIMEOUT_EN
      if (waits < 0 || waits >= TCYC) begin
         e.acc_cycles = TCYC;
         e.lat        = 2 + TCYC;
         e.rdata      = 32'h0;
         e.err        = 1'b1;
         e.tmo        = 1'b1;
         return e;
      end
`endif
      e.acc_cycles = waits + 1;
      e.lat        = 2 + e.acc_cycles;
      e.rdata      = wr ? 32'h0 : rd;
      e.err        = err_rdy;
      e.tmo        = 1'b0;
      return e;
   endfunction

   // Drives one command, plays the APB slave and the response sink, and
   // records what the DUT did. Called at a negedge; returns at the negedge
   // after the response handshake.
   task automatic xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                       input logic [2:0] prot, input int waits, input logic [31:0] rd,
                       input bit err_rdy, input bit noise_err, input int hold,
                       input bit keep_valid, output obs_t o);
      int k;
      int acc_n;
      o.done = 0; o.acc_cyc = -1; o.lat_psel = -1; o.lat_pen = -1; o.lat_rsp = -1;
      o.acc_cycles = 0; o.rdata = 'x; o.err = 'x; o.tmo = 'x;
      o.bus_ok = 1; o.hold_ok = 1; o.post_ok = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = addr;
      bus.cmd_write = wr;
      bus.cmd_wdata = wdata;
      bus.cmd_prot  = prot;
      bus.rsp_ready = 1'b0;
      k = 0;
      while (bus.cmd_ready !== 1'b1 && k < 50) begin
         @(negedge pclk);
         k++;
      end
      if (k >= 50) begin
         bus.cmd_valid = 1'b0;
         return;
      end
      @(negedge pclk);
      o.acc_cyc = cyc;
      if (!keep_valid) bus.cmd_valid = 1'b0;
      acc_n = 0;
      for (k = 1; k <= 200; k++) begin
         if (bus.psel === 1'b1 && o.lat_psel < 0) o.lat_psel = k;
         if (bus.penable === 1'b1 && o.lat_pen < 0) o.lat_pen = k;
         if (bus.psel === 1'b1) begin
            if (bus.paddr !== addr || bus.pwrite !== wr || bus.pwdata !== wdata ||
                bus.pprot !== prot) o.bus_ok = 0;
         end
         if (bus.penable === 1'b1 && bus.psel !== 1'b1) o.bus_ok = 0;
         if (bus.rsp_valid === 1'b1) begin
            o.lat_rsp = k;
            o.rdata   = bus.rsp_rdata;
            o.err     = bus.rsp_err;
            o.tmo     = bus.rsp_timeout;
            break;
         end
         if (bus.psel === 1'b1 && bus.penable === 1'b1) begin
            acc_n++;
            if (acc_n - 1 == waits) begin
               bus.pready  = 1'b1;
               bus.prdata  = rd;
               bus.pslverr = err_rdy;
            end else begin
               bus.pready  = 1'b0;
               bus.prdata  = $urandom;
               bus.pslverr = noise_err;
            end
         end else begin
            // Outside ACCESS the slave lines carry junk the DUT must ignore.
            bus.pready  = 1'($urandom);
            bus.prdata  = $urandom;
            bus.pslverr = 1'($urandom);
         end
         @(negedge pclk);
      end
      o.acc_cycles = acc_n;
      if (o.lat_rsp < 0) begin
         bus.cmd_valid = 1'b0;
         bus.pready    = 1'b0;
         return;
      end
      if (bus.cmd_ready !== 1'b0 || bus.psel !== 1'b0 || bus.penable !== 1'b0) o.hold_ok = 0;
      for (int h = 0; h < hold; h++) begin
         bus.rsp_ready = 1'b0;
         bus.pready    = 1'($urandom);
         bus.pslverr   = 1'($urandom);
         bus.prdata    = $urandom;
         @(negedge pclk);
         if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== o.rdata || bus.rsp_err !== o.err ||
             bus.rsp_timeout !== o.tmo || bus.cmd_ready !== 1'b0 || bus.psel !== 1'b0)
            o.hold_ok = 0;
      end
      bus.rsp_ready = 1'b1;
      @(negedge pclk);
      bus.rsp_ready = 1'b0;
      bus.pready    = 1'b0;
      bus.pslverr   = 1'b0;
      o.post_ok = (bus.rsp_valid === 1'b0 && bus.cmd_ready === 1'b1 && bus.psel === 1'b0);
      o.done = 1;
   endtask

   task automatic test_reset();
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = 32'h1234_5678;
      bus.cmd_write = 1'b1;
      bus.cmd_wdata = 32'hFFFF_FFFF;
      bus.cmd_prot  = 3'b111;
      bus.rsp_ready = 1'b0;
      bus.prdata    = 32'hFFFF_FFFF;
      bus.pready    = 1'b1;
      bus.pslverr   = 1'b1;
      repeat (3) @(negedge pclk);
      n_checks++;
      if ({bus.cmd_ready, bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err,
           bus.rsp_timeout} !== 7'b1000000)
         $display("FAIL reset_ctrl: got %b want 1000000", {bus.cmd_ready, bus.psel, bus.penable,
                  bus.pwrite, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout});
      else n_pass++;
      n_checks++;
      if (bus.paddr !== '0) $display("FAIL reset_paddr: got %h want 0", bus.paddr);
      else n_pass++;
      n_checks++;
      if (bus.pwdata !== 32'h0 || bus.pprot !== 3'h0)
         $display("FAIL reset_pwdata_pprot: got %h/%h want 0/0", bus.pwdata, bus.pprot);
      else n_pass++;
      n_checks++;
      if (bus.rsp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", bus.rsp_rdata);
      else n_pass++;
      bus.cmd_valid = 1'b0;
      bus.pready    = 1'b0;
      bus.pslverr   = 1'b0;
      preset = 1'b0;
      @(negedge pclk);
      n_checks++;
      if (bus.cmd_ready !== 1'b1 || bus.psel !== 1'b0)
         $display("FAIL reset_release_idle: got ready=%b psel=%b want 1/0", bus.cmd_ready, bus.psel);
      else n_pass++;
   endtask

   task automatic test_read_basic();
      obs_t o;
      exp_t e;
      e = model(1'b0, 32'hA5A5_1234, 1'b0, 0);
      xfer(32'h4001_1004, 1'b0, 32'h0BAD_F00D, 3'b001, 0, 32'hA5A5_1234, 1'b0, 1'b0, 0, 1'b0, o);
      n_checks++;
      if (!o.done) $display("FAIL rd_done: transfer did not finish within bound");
      else n_pass++;
      n_checks++;
      if (o.lat_psel != 1 || o.lat_pen != 2 || o.lat_rsp != e.lat)
         $display("FAIL rd_latency: got psel=%0d pen=%0d rsp=%0d want 1/2/%0d",
                  o.lat_psel, o.lat_pen, o.lat_rsp, e.lat);
      else n_pass++;
      n_checks++;
      if (o.rdata !== e.rdata || o.err !== e.err || o.tmo !== e.tmo)
         $display("FAIL rd_rsp: got %h err=%b tmo=%b want %h err=%b tmo=%b",
                  o.rdata, o.err, o.tmo, e.rdata, e.err, e.tmo);
      else n_pass++;
      n_checks++;
      if (!o.bus_ok || !o.post_ok)
         $display("FAIL rd_bus: got bus_ok=%0d post_ok=%0d want 1/1", o.bus_ok, o.post_ok);
      else n_pass++;
   endtask

   task automatic test_write_wait();
      obs_t o;
      exp_t e;
      e = model(1'b1, 32'h7777_7777, 1'b0, 3);
      xfer(32'h4001_1000, 1'b1, 32'hDEAD_BEEF, 3'b010, 3, 32'h7777_7777, 1'b0, 1'b0, 1, 1'b0, o);
      n_checks++;
      if (!o.done || o.lat_rsp != e.lat || o.acc_cycles != e.acc_cycles)
         $display("FAIL wr_latency: got done=%0d rsp=%0d acc=%0d want 1/%0d/%0d",
                  o.done, o.lat_rsp, o.acc_cycles, e.lat, e.acc_cycles);
      else n_pass++;
      n_checks++;
      if (o.rdata !== e.rdata || o.err !== e.err)
         $display("FAIL wr_rsp: got %h err=%b want %h err=%b", o.rdata, o.err, e.rdata, e.err);
      else n_pass++;
      n_checks++;
      if (!o.bus_ok || !o.hold_ok)
         $display("FAIL wr_stable: got bus_ok=%0d hold_ok=%0d want 1/1", o.bus_ok, o.hold_ok);
      else n_pass++;
   endtask

   task automatic test_slverr();
      obs_t o;
      exp_t e;
      e = model(1'b0, 32'h1111_2222, 1'b1, 2);
      xfer(32'h4001_2000, 1'b0, 32'h0, 3'b000, 2, 32'h1111_2222, 1'b1, 1'b0, 0, 1'b0, o);
      n_checks++;
      if (!o.done || o.err !== e.err || o.rdata !== e.rdata)
         $display("FAIL slverr_ready: got done=%0d err=%b rdata=%h want 1/%b/%h",
                  o.done, o.err, o.rdata, e.err, e.rdata);
      else n_pass++;
      e = model(1'b0, 32'h3333_4444, 1'b0, 2);
      xfer(32'h4001_2004, 1'b0, 32'h0, 3'b000, 2, 32'h3333_4444, 1'b0, 1'b1, 0, 1'b0, o);
      n_checks++;
      if (!o.done || o.err !== e.err || o.rdata !== e.rdata)
         $display("FAIL slverr_wait_ignored: got done=%0d err=%b rdata=%h want 1/%b/%h",
                  o.done, o.err, o.rdata, e.err, e.rdata);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      obs_t o1;
      obs_t o2;
      exp_t e1;
      exp_t e2;
      e1 = model(1'b0, 32'hCAFE_0001, 1'b0, 0);
      xfer(32'h4002_0000, 1'b0, 32'h0, 3'b100, 0, 32'hCAFE_0001, 1'b0, 1'b0, 5, 1'b1, o1);
      e2 = model(1'b0, 32'hCAFE_0002, 1'b0, 0);
      xfer(32'h4002_0000, 1'b0, 32'h0, 3'b100, 0, 32'hCAFE_0002, 1'b0, 1'b0, 0, 1'b0, o2);
      n_checks++;
      if (!o1.done || !o1.hold_ok || o1.rdata !== e1.rdata)
         $display("FAIL b2b_hold: got done=%0d hold_ok=%0d rdata=%h want 1/1/%h",
                  o1.done, o1.hold_ok, o1.rdata, e1.rdata);
      else n_pass++;
      n_checks++;
      if (o2.acc_cyc - o1.acc_cyc != e1.lat + 5 + 1)
         $display("FAIL b2b_gap: got %0d cycles want %0d", o2.acc_cyc - o1.acc_cyc, e1.lat + 6);
      else n_pass++;
      n_checks++;
      if (!o2.done || o2.rdata !== e2.rdata || o2.lat_rsp != e2.lat)
         $display("FAIL b2b_second: got done=%0d rdata=%h lat=%0d want 1/%h/%0d",
                  o2.done, o2.rdata, o2.lat_rsp, e2.rdata, e2.lat);
      else n_pass++;
      // Minimum period: no response stall, command waiting.
      xfer(32'h4002_0010, 1'b1, 32'h55AA_55AA, 3'b000, 0, 32'h0, 1'b0, 1'b0, 0, 1'b1, o1);
      xfer(32'h4002_0010, 1'b1, 32'h55AA_55AA, 3'b000, 0, 32'h0, 1'b0, 1'b0, 0, 1'b0, o2);
      n_checks++;
      if (!o2.done || o2.acc_cyc - o1.acc_cyc != 4)
         $display("FAIL b2b_min_period: got done=%0d gap=%0d want 1/4", o2.done,
                  o2.acc_cyc - o1.acc_cyc);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      obs_t o;
      exp_t e;
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = 32'h4003_0000;
      bus.cmd_write = 1'b0;
      bus.cmd_wdata = 32'h0;
      bus.cmd_prot  = 3'b000;
      @(negedge pclk);
      bus.cmd_valid = 1'b0;
      bus.pready    = 1'b1;
      @(negedge pclk);
      bus.pready    = 1'b0;
      n_checks++;
      if (bus.psel !== 1'b1 || bus.penable !== 1'b1)
         $display("FAIL rstmid_access: got psel=%b penable=%b want 1/1", bus.psel, bus.penable);
      else n_pass++;
      #2;
      preset     = 1'b1;
      bus.pready = 1'b1;
      #1;
      n_checks++;
      if ({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready} !== 4'b0001)
         $display("FAIL rstmid_async: got %b want 0001",
                  {bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready});
      else n_pass++;
      @(negedge pclk);
      preset     = 1'b0;
      bus.pready = 1'b0;
      @(negedge pclk);
      n_checks++;
      if ({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready} !== 4'b0001)
         $display("FAIL rstmid_idle: got %b want 0001",
                  {bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready});
      else n_pass++;
      e = model(1'b0, 32'h600D_0005, 1'b0, 1);
      xfer(32'h4003_0004, 1'b0, 32'h0, 3'b011, 1, 32'h600D_0005, 1'b0, 1'b0, 0, 1'b0, o);
      n_checks++;
      if (!o.done || o.rdata !== e.rdata || o.lat_rsp != e.lat || !o.bus_ok)
         $display("FAIL rstmid_after: got done=%0d rdata=%h lat=%0d bus_ok=%0d want 1/%h/%0d/1",
                  o.done, o.rdata, o.lat_rsp, o.bus_ok, e.rdata, e.lat);
      else n_pass++;
   endtask

   task automatic test_random();
      obs_t        o;
      exp_t        e;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      logic [2:0]  prot;
      bit          wr;
      bit          er;
      bit          nz;
      int          waits;
      int          hold;
      for (int i = 0; i < 24; i++) begin
         addr  = $urandom;
         wd    = $urandom;
         rd    = $urandom;
         prot  = 3'($urandom);
         wr    = 1'($urandom);
         er    = 1'($urandom);
         nz    = 1'($urandom);
         waits = $urandom_range(0, 5);
         hold  = $urandom_range(0, 2);
         e = model(wr, rd, er, waits);
         xfer(addr, wr, wd, prot, waits, rd, er, nz, hold, 1'b0, o);
         n_checks++;
         if (!o.done || o.lat_psel != 1 || o.lat_pen != 2 || o.lat_rsp != e.lat)
            $display("FAIL rand%0d_timing: got done=%0d psel=%0d pen=%0d rsp=%0d want 1/1/2/%0d",
                     i, o.done, o.lat_psel, o.lat_pen, o.lat_rsp, e.lat);
         else n_pass++;
         n_checks++;
         if (o.rdata !== e.rdata || o.err !== e.err || o.tmo !== e.tmo)
            $display("FAIL rand%0d_rsp: got %h err=%b tmo=%b want %h err=%b tmo=%b",
                     i, o.rdata, o.err, o.tmo, e.rdata, e.err, e.tmo);
         else n_pass++;
         n_checks++;
         if (!o.bus_ok || !o.hold_ok || !o.post_ok)
            $display("FAIL rand%0d_bus: got bus=%0d hold=%0d post=%0d want 1/1/1",
                     i, o.bus_ok, o.hold_ok, o.post_ok);
         else n_pass++;
      end
   endtask

`ifdef APB_MST_TIMEOUT_EN
   task automatic test_timeout();
      obs_t o;
      exp_t e;
      e = model(1'b0, 32'h9999_9999, 1'b0, -1);
      xfer(32'h4004_0000, 1'b0, 32'h0, 3'b000, -1, 32'h9999_9999, 1'b0, 1'b1, 0, 1'b0, o);
      n_checks++;
      if (!o.done || o.acc_cycles != e.acc_cycles || o.lat_rsp != e.lat)
         $display("FAIL tmo_timing: got done=%0d acc=%0d lat=%0d want 1/%0d/%0d",
                  o.done, o.acc_cycles, o.lat_rsp, e.acc_cycles, e.lat);
      else n_pass++;
      n_checks++;
      if (o.err !== e.err || o.tmo !== e.tmo || o.rdata !== e.rdata)
         $display("FAIL tmo_rsp: got err=%b tmo=%b rdata=%h want %b/%b/%h",
                  o.err, o.tmo, o.rdata, e.err, e.tmo, e.rdata);
      else n_pass++;
      // pready in the last allowed cycle completes normally.
      e = model(1'b0, 32'h8888_0007, 1'b0, TCYC - 1);
      xfer(32'h4004_0004, 1'b0, 32'h0, 3'b000, TCYC - 1, 32'h8888_0007, 1'b0, 1'b0, 0, 1'b0, o);
      n_checks++;
      if (!o.done || o.tmo !== e.tmo || o.err !== e.err || o.rdata !== e.rdata || o.lat_rsp != e.lat)
         $display("FAIL tmo_boundary: got done=%0d tmo=%b err=%b rdata=%h lat=%0d want 1/%b/%b/%h/%0d",
                  o.done, o.tmo, o.err, o.rdata, o.lat_rsp, e.tmo, e.err, e.rdata, e.lat);
      else n_pass++;
   endtask
`endif

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_write = 1'b0;
      bus.cmd_wdata = '0;
      bus.cmd_prot  = '0;
      bus.rsp_ready = 1'b0;
      bus.prdata    = '0;
      bus.pready    = 1'b0;
      bus.pslverr   = 1'b0;
      test_reset();
      test_read_basic();
      test_write_wait();
      test_slverr();
      test_back_to_back();
      test_reset_mid();
      test_random();
`ifdef APB_MST_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
